// File: rtl/seg7_pkg.sv
// seg7_pkg: shared nibble/segment types and the 7-segment pattern table
// Segment bit order is {a,b,c,d,e,f,g} in bits [6:0], active-low (0 = lit).
// Codes 10..14 use the TTL 7447 symbol set, and code 15 is blank.
package seg7_pkg;
  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK  = 7'h7F;
  localparam seg_t SEG_ALL_ON = 7'h00;
  localparam seg_t SEG_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h72, 7'h66, 7'h5C, 7'h34, 7'h70, 7'h7F
  };
  function automatic seg_t seg_lookup(input nibble_t n);
    return SEG_TABLE[n];
  endfunction
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: combinational nibble-to-segment decoder with blanking and lamp test
// Ports:
//   nibble - input code to display
//   lt     - lamp test, active-low
//   bi     - blank input, active-low
//   blank  - leading-zero blank request
//   seg_n  - segment outputs, active-low
// Priority: bi low, then lt low, then blank, then normal decode.
module seg7_dec
  import seg7_pkg::*;
(
  input  nibble_t nibble,
  input  logic    lt,
  input  logic    bi,
  input  logic    blank,
  output seg_t    seg_n
);
  assign seg_n = !bi ? SEG_BLANK : !lt ? SEG_ALL_ON : blank ? SEG_BLANK : seg_lookup(nibble);
endmodule

// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: multiplexed NDIG-digit 7-segment scan driver
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   din, ld    - display nibbles (digit 0 in [3:0]) and their latch strobe
//   lt, bi     - lamp test and blank-all, both active-low
//   lzb        - leading-zero blanking enable
//   seg_n      - registered segments {a..g}, active-low
//   an_n       - registered one-hot digit enables, active-low
//   dp, dp_n   - decimal points in and registered out, only when SEG7_DP_EN is defined
// Every slot opens with one clock of all-off anodes, which prevents ghosting.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] din,
  input  logic              ld,
  input  logic              lt,
  input  logic              bi,
  input  logic              lzb,
`ifdef SEG7_DP_EN
  input  logic [NDIG-1:0]   dp,
  output logic              dp_n,
`endif
  output logic [6:0]        seg_n,
  output logic [NDIG-1:0]   an_n
);
  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NDIG);
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [4*NDIG-1:0] disp;
  nibble_t digs [NDIG];
  logic [NDIG-1:0] lz;
  logic run;
  seg_t seg_d;
  logic pre_wrap, idx_wrap;
  assign pre_wrap = pre == PW'(PRESCALE - 1);
  assign idx_wrap = idx == IW'(NDIG - 1);
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign digs[g] = disp[4*g +: 4];
  end
  // A digit is blanked only if it is zero and every digit above it is blanked.
  // Digit 0 is never blanked, so that a zero value still shows "0".
  always_comb begin
    lz = '0;
    run = lzb;
    for (int i = NDIG - 1; i > 0; i--) begin
      run = run && (digs[i] == 4'h0);
      lz[i] = run;
    end
  end
  seg7_dec u_dec (
    .nibble(digs[idx]),
    .lt    (lt),
    .bi    (bi),
    .blank (lz[idx]),
    .seg_n (seg_d)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre   <= '0;
      idx   <= '0;
      disp  <= '0;
      seg_n <= SEG_BLANK;
      an_n  <= '1;
    end else begin
      if (ld) disp <= din;
      pre <= pre_wrap ? '0 : pre + 1'b1;
      if (pre_wrap) idx <= idx_wrap ? '0 : idx + 1'b1;
      seg_n <= seg_d;
      an_n  <= (pre == '0) ? '1 : ~(NDIG'(1) << idx);
    end
`ifdef SEG7_DP_EN
  logic [NDIG-1:0] dp_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dp_r <= '0;
      dp_n <= 1'b1;
    end else begin
      if (ld) dp_r <= dp;
      dp_n <= !bi ? 1'b1 : !lt ? 1'b0 : ~dp_r[idx];
    end
`endif
endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv: directed self-checking bench for seg7_scan_drv (NDIG=4, PRESCALE=4)
module tb_seg7_scan_drv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld = 1'b0;
  logic lt = 1'b1;
  logic bi = 1'b1;
  logic lzb = 1'b0;
  logic [15:0] din = '0;
  logic [6:0] seg_n;
  logic [3:0] an_n;
`ifdef SEG7_DP_EN
  logic [3:0] dp = '0;
  logic dp_n;
`endif
  int checks = 0;
  int errors = 0;
  int k = 0;
  always #5 clk = ~clk;
  seg7_scan_drv #(.NDIG(4), .PRESCALE(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .ld   (ld),
    .lt   (lt),
    .bi   (bi),
    .lzb  (lzb),
`ifdef SEG7_DP_EN
    .dp   (dp),
    .dp_n (dp_n),
`endif
    .seg_n(seg_n),
    .an_n (an_n)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // k counts edges since reset release; the output seen after edge k shows
  // the scan state after k-1 edges: count (k-1)%4 of digit ((k-1)/4)%4.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask
  function automatic logic [3:0] exp_an(input int kk);
    return ((kk - 1) % 4 == 0) ? 4'hF : ~(4'b0001 << ((kk - 1) / 4 % 4));
  endfunction
  task automatic load(input logic [15:0] v);
    din = v;
    ld = 1'b1;
    tick;
    chk("an_load", an_n, exp_an(k));
    ld = 1'b0;
  endtask
  task automatic run16(input logic [6:0] e3, input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] e [4];
    e = '{e0, e1, e2, e3};
    repeat (16) begin
      tick;
      chk("an_scan", an_n, exp_an(k));
      if ((k - 1) % 4 != 0) chk("seg_scan", seg_n, e[(k - 1) / 4 % 4]);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("seg_rst", seg_n, 7'h7F);
    chk("an_rst", an_n, 4'hF);
    rst = 1'b0;
    k = 0;
    tick;
    chk("an_first_gap", an_n, 4'hF);
    tick;
    chk("an_first_low", an_n, 4'hE);
    chk("seg_first", seg_n, 7'h01);
    load(16'h1234);
    run16(7'h4F, 7'h12, 7'h06, 7'h4C);
    lzb = 1'b1;
    load(16'h0050);
    run16(7'h7F, 7'h7F, 7'h24, 7'h01);
    load(16'h0000);
    run16(7'h7F, 7'h7F, 7'h7F, 7'h01);
    load(16'h0500);
    run16(7'h7F, 7'h24, 7'h01, 7'h01);
    lzb = 1'b0;
    load(16'h1234);
    lt = 1'b0;
    bi = 1'b0;
    run16(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    bi = 1'b1;
    run16(7'h00, 7'h00, 7'h00, 7'h00);
    lt = 1'b1;
    load(16'h1334);
    for (int i = 0; i < 16 && !(((k - 1) % 4 == 1) && ((k - 1) / 4 % 4 == 2)); i++) tick;
    chk("an_mid_d2", an_n, 4'hB);
    din = 16'h1734;
    ld = 1'b1;
    tick;
    ld = 1'b0;
    chk("seg_mid_old", seg_n, 7'h06);
    tick;
    chk("seg_mid_new", seg_n, 7'h0F);
    chk("an_mid_hold", an_n, 4'hB);
    tick;
    chk("an_mid_gap", an_n, 4'hF);
    tick;
    chk("an_mid_next", an_n, 4'h7);
    chk("seg_mid_next", seg_n, 7'h4F);
`ifdef SEG7_DP_EN
    dp = 4'b0010;
    load(16'h1234);
    repeat (16) begin
      tick;
      chk("dp_scan", {7'd0, dp_n}, ((k - 1) / 4 % 4 == 1) ? 8'd0 : 8'd1);
    end
    bi = 1'b0;
    repeat (8) begin
      tick;
      chk("dp_bi", {7'd0, dp_n}, 8'd1);
    end
    bi = 1'b1;
`endif
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("seg_rst_async", seg_n, 7'h7F);
    chk("an_rst_async", an_n, 4'hF);
    @(negedge clk);
    chk("an_rst_hold", an_n, 4'hF);
    rst = 1'b0;
    k = 0;
    tick;
    chk("an_rel_gap", an_n, 4'hF);
    tick;
    chk("an_rel_low", an_n, 4'hE);
    chk("seg_rel", seg_n, 7'h01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_drv.md
SEG7_SCAN_DRV -- requirements
Module: seg7_scan_drv

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning the number of multiplexed digits (2..8).
REQ-002 SHALL have parameter PRESCALE, default 16, meaning clocks per digit slot (>=2).
REQ-003 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port din, input, 4*NDIG bits: BCD/hex nibbles, digit 0 (LSD) in bits [3:0].
REQ-006 SHALL have port ld, input, 1 bit: latch strobe for din.
REQ-007 SHALL have port lt, input, 1 bit: lamp test, active-low.
REQ-008 SHALL have port bi, input, 1 bit: blank all, active-low.
REQ-009 SHALL have port lzb, input, 1 bit: leading-zero blanking enable, active-high.
REQ-010 SHALL have port seg_n, output, 7 bits: segments a..g in bits [6:0], 0 = lit.
REQ-011 SHALL have port an_n, output, NDIG bits: digit enables, one-hot active-low.

Function
REQ-012 SHALL sample din into an internal display register on every rising clk edge with ld=1; ld=0 holds it.
REQ-013 SHALL run a prescaler 0..PRESCALE-1 and advance the digit index at prescaler wrap, cycling 0..NDIG-1 and wrapping to 0.
REQ-014 SHALL register seg_n and an_n so that both reflect the prescaler/index state one clock later.
REQ-015 SHALL drive an_n all-1 during prescaler count 0 of every slot (anti-ghost gap), and assert only bit [index] low for counts 1..PRESCALE-1.
REQ-016 SHALL decode nibbles 0-9 as standard 7-segment digits (0 = 7'b0000001, 1 = 7'b1001111, 8 = 7'b0000000) and 10-14 as the classic TTL symbol set; 15 SHALL be blank (7'b1111111).
REQ-017 SHALL blank digit i when lzb=1, its nibble is 0, and every higher digit is also blanked; digit 0 SHALL never be leading-zero blanked.
REQ-018 SHALL apply the priority bi=0 (all segments off) over lt=0 (all segments on) over leading-zero blanking over normal decode.
REQ-019 SHALL keep an_n scanning while bi=0 or lt=0.
REQ-020 SHALL take an ld occurring mid-slot into the currently displayed digit one clock after capture; the slot timing SHALL NOT restart.

Reset
REQ-021 SHALL, while rst=1, force prescaler=0, index=0, display register=0, seg_n=7'b1111111 and an_n=all-1, regardless of clk.
REQ-022 SHALL, on rst deassertion, show the first an_n low at the second clk edge (prescaler count 1 of digit 0).

Configuration
REQ-023 SHALL, with SEG7_DP_EN defined, add input dp (NDIG bits, latched with din by ld) and registered output dp_n (0 = lit, follows the scanned digit, forced 1 by bi=0, forced 0 by lt=0, reset 1).
REQ-024 SHALL, without SEG7_DP_EN, have neither dp nor dp_n ports and no decimal-point logic.

Structure
REQ-025 SHALL put the 16-entry segment pattern table, the blank and all-on constants, and the nibble/segment typedefs in package seg7_pkg.
REQ-026 SHALL use one combinational sub-module seg7_dec (nibble, lt, bi, blank in; 7-bit seg_n out), instantiated once on the scanned digit.

Verification
REQ-027 SHALL cover: rst pulse mid-scan with NDIG=4, PRESCALE=4 -> seg_n=7'h7F and an_n=4'hF immediately, then an_n=4'hE at the second edge after release.
REQ-028 SHALL cover: ld with din=16'h1234, lzb=0 -> per slot an_n E/D/B/7 with seg_n 4/3/2/1 patterns, and an_n=4'hF on the first clock of each slot.
REQ-029 SHALL cover: din=16'h0050, lzb=1 -> digit 3 and digit 2 blank (7'h7F), digit 1 shows 5, digit 0 shows 0; din=16'h0000 -> only digit 0 lit ("0").
REQ-030 SHALL cover: lt=0 and bi=0 together -> seg_n=7'h7F; lt=0 alone -> seg_n=7'h00 on every slot while an_n continues to scan.
REQ-031 SHALL cover: ld pulsed mid-slot of digit 2 changing its nibble 3->7 -> seg_n switches to the 7 pattern one clock later and slot length stays PRESCALE.
REQ-032 SHALL cover: with SEG7_DP_EN, dp=4'b0010 -> dp_n=0 only during digit 1 slots, and dp_n=1 while bi=0.
